ex_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the LEGv8 execute/memory datapath.
- Tracks destination registers of instructions in flight (EX, MEM, WB) in an internal shadow pipeline.
- Drives ALU operand forwarding selects, inserts load-use bubbles, and flushes younger stages when a branch resolves taken in MEM.
- Sits beside the ID/EX boundary; consumes decode fields and PCSrc, and produces stall, flush and forward controls.

---
 rtl/ex_hazard_ctrl_pkg.sv | 37 +++
 rtl/hz_fwd_match.sv | 34 +++
 rtl/ex_hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the LEGv8 EX/MEM hazard controller and the execute-stage operand muxes.
// The optional EX_HAZARD_CTRL_PERF_EN build only affects the top module.
package ex_hazard_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam logic [REG_W_DEF-1:0] ZERO_REG = 5'd31;

  // Shadow pipeline slot indices.
  localparam int SH_EX  = 0;
  localparam int SH_MEM = 1;
  localparam int SH_WB  = 2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } shadow_entry_t;

  // True when the entry is a live register writer targeting src.
  function automatic logic stage_hit(shadow_entry_t e, logic [REG_W_DEF-1:0] src);
    return e.valid && e.reg_write && (e.rd == src);
  endfunction

endpackage

// File: rtl/hz_fwd_match.sv
// Compares one ID source register against the EX and MEM shadow entries and
// returns the operand-forward select; the nearer (EX) stage wins.
module hz_fwd_match
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_IDX = 31
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_en,
  input  shadow_entry_t    ex_e,
  input  shadow_entry_t    mem_e,
  output fwd_sel_t         sel
);

  logic live;
  logic ex_hit;
  logic mem_hit;

  // XZR reads as zero, so it never depends on an in-flight writer.
  assign live    = src_en && (src != REG_W'(ZERO_IDX));
  assign ex_hit  = live && stage_hit(ex_e, src);
  assign mem_hit = live && stage_hit(mem_e, src);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB tracking, registered forwarding,
// load-use stall and taken-branch flush. Define EX_HAZARD_CTRL_PERF_EN for stall/flush counters.
module ex_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int ZERO_REG     = 31,
  parameter int FLUSH_CYCLES = 1
`ifdef EX_HAZARD_CTRL_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             pcsrc,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o
`ifdef EX_HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  import ex_hazard_ctrl_pkg::shadow_entry_t;
  import ex_hazard_ctrl_pkg::fwd_sel_t;
  import ex_hazard_ctrl_pkg::hz_state_t;
  import ex_hazard_ctrl_pkg::FWD_RF;
  import ex_hazard_ctrl_pkg::FWD_EX;
  import ex_hazard_ctrl_pkg::RUN;
  import ex_hazard_ctrl_pkg::STALL;
  import ex_hazard_ctrl_pkg::FLUSH;
  import ex_hazard_ctrl_pkg::SH_EX;
  import ex_hazard_ctrl_pkg::SH_MEM;
  import ex_hazard_ctrl_pkg::SH_WB;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  shadow_entry_t stage_q [3];
  hz_state_t     state_q;
  logic [2:0]    flush_left_q;
  logic          flush_q;
  fwd_sel_t      sel_a;
  fwd_sel_t      sel_b;
  fwd_sel_t      fwd_a_q;
  fwd_sel_t      fwd_b_q;
  logic          load_use;
  logic          squash;
  logic          stall_c;
  logic          issue;

  hz_fwd_match #(
    .REG_W    (REG_W),
    .ZERO_IDX (ZERO_REG)
  ) u_match_rn (
    .src    (id_rn),
    .src_en (id_valid),
    .ex_e   (stage_q[SH_EX]),
    .mem_e  (stage_q[SH_MEM]),
    .sel    (sel_a)
  );

  hz_fwd_match #(
    .REG_W    (REG_W),
    .ZERO_IDX (ZERO_REG)
  ) u_match_rm (
    .src    (id_rm),
    .src_en (id_valid && id_uses_rm),
    .ex_e   (stage_q[SH_EX]),
    .mem_e  (stage_q[SH_MEM]),
    .sel    (sel_b)
  );

  // A load in EX feeding either live source needs one bubble; a taken branch
  // (now or still flushing) overrides it.
  assign load_use = stage_q[SH_EX].mem_read && ((sel_a == FWD_EX) || (sel_b == FWD_EX));
  assign squash   = pcsrc || flush_q;
  assign stall_c  = load_use && !squash;
  assign issue    = id_valid && !stall_c && !squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = SH_EX; i <= SH_WB; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = SH_WB; i > SH_EX; i--) begin
        stage_q[i] <= stage_q[i-1];
      end
      // The instruction leaving EX is younger than the branch; WB is older and kept.
      if (squash) begin
        stage_q[SH_MEM].valid <= 1'b0;
      end
      if (issue) begin
        stage_q[SH_EX].valid     <= 1'b1;
        stage_q[SH_EX].rd        <= id_rd;
        stage_q[SH_EX].reg_write <= id_reg_write;
        stage_q[SH_EX].mem_read  <= id_mem_read;
      end else begin
        stage_q[SH_EX] <= '0;
      end
    end
  end

  // Selects are registered so they line up with the instruction entering EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (issue) begin
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
    end else begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_left_q <= '0;
      flush_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (pcsrc) begin
            state_q      <= FLUSH;
            flush_left_q <= FLUSH_LOAD;
            flush_q      <= 1'b1;
          end else if (stall_c) begin
            state_q <= STALL;
          end
        end
        STALL: begin
          if (pcsrc) begin
            state_q      <= FLUSH;
            flush_left_q <= FLUSH_LOAD;
            flush_q      <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        FLUSH: begin
          if (pcsrc) begin
            flush_left_q <= FLUSH_LOAD;
          end else if (flush_left_q == 3'd0) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_left_q <= flush_left_q - 3'd1;
          end
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall   = stall_c;
  assign flush   = flush_q;
  assign fwd_a   = fwd_a_q;
  assign fwd_b   = fwd_b_q;
  assign state_o = state_q;

`ifdef EX_HAZARD_CTRL_PERF_EN
  logic flush_entry;

  assign flush_entry = pcsrc && (state_q != FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (flush_entry && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: per-cycle vector table plus flush/stall/reset sequences.
module tb_ex_hazard_ctrl;

  localparam int REG_W  = 5;
  localparam int PERF_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rn = '0;
  logic [REG_W-1:0] id_rm = '0;
  logic             id_uses_rm = 1'b0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_reg_write = 1'b0;
  logic             id_mem_read = 1'b0;
  logic             pcsrc = 1'b0;
  logic             stall;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state_o;
`ifdef EX_HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
`endif

  ex_hazard_ctrl #(
    .REG_W        (REG_W),
    .ZERO_REG     (31),
    .FLUSH_CYCLES (2)
`ifdef EX_HAZARD_CTRL_PERF_EN
    ,
    .PERF_W       (PERF_W)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rm   (id_uses_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .pcsrc        (pcsrc),
    .stall        (stall),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .state_o      (state_o)
`ifdef EX_HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int v, rn, rm, u, rd, rw, mr, pc;
    int e_stall, e_flush, e_fa, e_fb, e_st;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];
  int         compared = 0;
  int         mismatched = 0;

  // Scoreboard
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input int v, input int rn, input int rm, input int u,
                       input int rd, input int rw, input int mr, input int pc);
    id_valid     = v[0];
    id_rn        = rn[REG_W-1:0];
    id_rm        = rm[REG_W-1:0];
    id_uses_rm   = u[0];
    id_rd        = rd[REG_W-1:0];
    id_reg_write = rw[0];
    id_mem_read  = mr[0];
    pcsrc        = pc[0];
  endtask

  task automatic nop(input int pc);
    drive(0, 0, 0, 0, 0, 0, 0, pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int v, input int rn, input int rm, input int u, input int rd,
                     input int rw, input int mr, input int pc, input int e_stall,
                     input int e_flush, input int e_fa, input int e_fb, input int e_st);
    vec_t t;
    t.v = v; t.rn = rn; t.rm = rm; t.u = u; t.rd = rd; t.rw = rw; t.mr = mr; t.pc = pc;
    t.e_stall = e_stall; t.e_flush = e_flush; t.e_fa = e_fa; t.e_fb = e_fb; t.e_st = e_st;
    vecs.push_back(t);
  endtask

  // Pops {flush, state} expectations one per cycle with idle inputs.
  task automatic drain(input string name);
    logic [2:0] e;
    int n = 0;
    while (exp_q.size() > 0) begin
      nop(0);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s%0d flush", name, n), int'(flush), int'(e[2]));
      check($sformatf("%s%0d state", name, n), int'(state_o), int'(e[1:0]));
      tick();
      n++;
    end
  endtask

  initial begin
    // Outputs are registered, so row N shows fwd for the instruction of row N-1.
    //   v rn rm u rd rw mr pc | stall flush fa fb st
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // 0 idle
    add(1, 2, 3, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0);  // 1 ADD X1,X2,X3
    add(1, 1, 5, 1, 4, 1, 0, 0,   0, 0, 0, 0, 0);  // 2 SUB X4,X1,X5
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 0);  // 3 SUB got EX forward
    add(1, 2, 3, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0);  // 4 ADD X1
    add(1, 2, 3, 1, 8, 1, 0, 0,   0, 0, 0, 0, 0);  // 5 filler X8
    add(1, 7, 1, 1, 6, 1, 0, 0,   0, 0, 0, 0, 0);  // 6 ORR X6,X7,X1
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);  // 7 ORR got MEM forward on B
    add(1, 10, 0, 0, 9, 1, 1, 0,  0, 0, 0, 0, 0);  // 8 LDUR X9
    add(1, 9, 12, 1, 11, 1, 0, 0, 1, 0, 0, 0, 0);  // 9 ADD X11,X9,X12 stalls
    add(1, 9, 12, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1);  // 10 held, bubble in EX
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // 11 ADD got MEM forward
    add(1, 2, 3, 1, 31, 1, 0, 0,  0, 0, 0, 0, 0);  // 12 writer of XZR
    add(1, 31, 31, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);  // 13 reader of XZR
    add(1, 2, 0, 0, 31, 1, 1, 0,  0, 0, 0, 0, 0);  // 14 load into XZR
    add(1, 31, 31, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);  // 15 no stall on XZR
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // 16
    add(1, 2, 3, 1, 7, 1, 0, 0,   0, 0, 0, 0, 0);  // 17 ADD X7
    add(1, 2, 7, 0, 8, 1, 0, 0,   0, 0, 0, 0, 0);  // 18 rm=X7 not read
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // 19 no forward on B
    add(1, 10, 0, 0, 9, 1, 1, 0,  0, 0, 0, 0, 0);  // 20 LDUR X9
    add(1, 1, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // 21 rm=X9 not read, no stall
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // 22
    add(1, 2, 4, 1, 3, 1, 0, 0,   0, 0, 0, 0, 0);  // 23 X3 writer (older)
    add(1, 5, 6, 1, 3, 1, 0, 0,   0, 0, 0, 0, 0);  // 24 X3 writer (newer)
    add(1, 3, 3, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0);  // 25 reader of X3
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 2, 0);  // 26 nearer stage wins
    add(1, 1, 0, 0, 12, 1, 1, 0,  0, 0, 0, 0, 0);  // 27 LDUR X12
    add(1, 2, 12, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);  // 28 STUR Rt=X12 stalls
    add(1, 2, 12, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);  // 29 held
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);  // 30 MEM forward on B

    // Reset state
    #3;
    check("reset stall", int'(stall), 0);
    check("reset flush", int'(flush), 0);
    check("reset fwd_a", int'(fwd_a), 0);
    check("reset fwd_b", int'(fwd_b), 0);
    check("reset state", int'(state_o), 0);
    #19 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rn, vecs[i].rm, vecs[i].u, vecs[i].rd,
            vecs[i].rw, vecs[i].mr, vecs[i].pc);
      @(negedge clk);
      check($sformatf("row%0d stall", i), int'(stall), vecs[i].e_stall);
      check($sformatf("row%0d flush", i), int'(flush), vecs[i].e_flush);
      check($sformatf("row%0d fwd_a", i), int'(fwd_a), vecs[i].e_fa);
      check($sformatf("row%0d fwd_b", i), int'(fwd_b), vecs[i].e_fb);
      check($sformatf("row%0d state", i), int'(state_o), vecs[i].e_st);
      tick();
    end

    // Taken branch coinciding with a load-use hazard
    drive(1, 1, 0, 0, 20, 1, 1, 0);
    @(negedge clk);
    check("f0 stall", int'(stall), 0);
    tick();
    drive(1, 20, 3, 1, 21, 1, 0, 1);
    @(negedge clk);
    check("f1 stall", int'(stall), 0);
    check("f1 flush", int'(flush), 0);
    check("f1 state", int'(state_o), 0);
    tick();
    exp_q.push_back({1'b1, 2'd2});
    exp_q.push_back({1'b1, 2'd2});
    exp_q.push_back({1'b0, 2'd0});
    drain("fseq");

    // Branch taken while stalled, then re-taken during flush
    drive(1, 1, 0, 0, 22, 1, 1, 0);
    @(negedge clk);
    check("g0 stall", int'(stall), 0);
    tick();
    drive(1, 22, 3, 1, 23, 1, 0, 0);
    @(negedge clk);
    check("g1 stall", int'(stall), 1);
    check("g1 state", int'(state_o), 0);
    tick();
    drive(1, 22, 3, 1, 23, 1, 0, 1);
    @(negedge clk);
    check("g2 stall", int'(stall), 0);
    check("g2 state", int'(state_o), 1);
    tick();
    nop(1);
    @(negedge clk);
    check("g3 flush", int'(flush), 1);
    check("g3 state", int'(state_o), 2);
    check("g3 stall", int'(stall), 0);
    tick();
    exp_q.push_back({1'b1, 2'd2});
    exp_q.push_back({1'b1, 2'd2});
    exp_q.push_back({1'b0, 2'd0});
    drain("gseq");
`ifdef EX_HAZARD_CTRL_PERF_EN
    check("perf stall_cnt", int'(stall_cnt), 3);
    check("perf flush_cnt", int'(flush_cnt), 2);
`endif

    // Reset in the middle of a flush
    nop(1);
    tick();
    nop(0);
    @(negedge clk);
    check("h flush before reset", int'(flush), 1);
    #2 rst_n = 1'b0;
    #1;
    check("h reset flush", int'(flush), 0);
    check("h reset state", int'(state_o), 0);
    check("h reset stall", int'(stall), 0);
    check("h reset fwd_a", int'(fwd_a), 0);
`ifdef EX_HAZARD_CTRL_PERF_EN
    check("h reset stall_cnt", int'(stall_cnt), 0);
    check("h reset flush_cnt", int'(flush_cnt), 0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    drive(1, 2, 3, 1, 1, 1, 0, 0);
    @(negedge clk);
    check("h add flush", int'(flush), 0);
    tick();
    drive(1, 1, 5, 1, 4, 1, 0, 0);
    @(negedge clk);
    check("h sub stall", int'(stall), 0);
    check("h sub fwd_a early", int'(fwd_a), 0);
    tick();
    nop(0);
    @(negedge clk);
    check("h sub fwd_a", int'(fwd_a), 2);
    check("h sub fwd_b", int'(fwd_b), 0);
    check("h state", int'(state_o), 0);
    tick();

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
